// File: rtl/qspi_pkg.sv
// Shared types and constants for the QPI-mode memory responder.
package qspi_pkg;

    // Frame progress of the responder FSM.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;

    // Flip-flops in every pin synchronizer (CS, SCK and data lanes).
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_edge.sv
// Pin synchronizer with edge detection on the synchronized level.
// rise_o/fall_o are combinational from the last sync stage versus its
// delayed copy, so an action taken on them lands one clk after the
// level is synchronized (2 sync + 1 detect from the pin).
module sync_edge
    import qspi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  prev_r;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sync_r <= {SYNC_DEPTH{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], d_i};
            prev_r <= sync_r[SYNC_DEPTH-1];
        end
    end

    // Level and edge strobes of the synchronized input.
    always_comb begin
        q_o    = sync_r[SYNC_DEPTH-1];
        rise_o = sync_r[SYNC_DEPTH-1] & ~prev_r;
        fall_o = ~sync_r[SYNC_DEPTH-1] & prev_r;
    end

endmodule

// File: rtl/qspi_mem_resp.sv
// QPI-mode QSPI memory responder: decodes command/address/data frames from
// an initiator and serves them from a byte-wide synchronous backing store.
// All pins are oversampled in clk_i; sd is sampled on SCK rise, sd_o is
// updated on SCK fall. A high synchronized CS always wins over SCK edges.
module qspi_mem_resp
    import qspi_pkg::*;
#(
    parameter int ADRW  = 24,
    parameter int DUMMY = 4
) (
    input  logic            clk_i,
    input  logic            rst_in,
    input  logic            cs_in,
    input  logic            sck_i,
    input  logic [3:0]      sd_i,
    output logic [3:0]      sd_o,
    output logic [3:0]      sd_oen_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [ADRW-1:0] mem_adr_o,
    output logic [7:0]      mem_wdat_o,
    input  logic [7:0]      mem_rdat_i,
    output logic            busy_o,
    output state_e          state_o
);

    localparam int ANIB = ADRW / 4;
    localparam int CNTW = 8;

    // Synchronized pins and edge strobes.
    logic       sck_s, sck_rise, sck_fall;
    logic       cs_s, cs_rise, cs_fall;
    logic [3:0] sd_sync [SYNC_DEPTH];
    logic [3:0] sd_s;
    logic       unused_ok;

    // FSM and datapath registers.
    state_e          state_r, state_nx;
    logic [CNTW-1:0] cnt_r;
    logic [7:0]      cmd_r;
    logic [ADRW-1:0] adr_r;
    logic            half_r;
    logic [3:0]      whi_r;
    logic [7:0]      pref_r;
    logic [7:0]      shift_r;
    logic            rd_pend_r;

    // Derived combinational terms.
    logic [7:0]      cmd_nx;
    logic [ADRW-1:0] adr_nx;
    logic [ADRW-1:0] adr_inc;
    logic            rise_act, fall_act;
    logic            last_cmd, last_adr, last_dmy;
    logic            cnt_en;

    sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .d_i    (sck_i),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // CS resets to its inactive (high) level so a frame needs a real fall.
    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .d_i    (cs_in),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Abort is level-driven by cs_s; the SCK level and CS rise strobe are not needed.
    assign unused_ok = ^{sck_s, cs_rise};

    // Plain synchronizer for the data lanes, same depth as SCK so they stay aligned.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SYNC_DEPTH; i++) sd_sync[i] <= 4'h0;
        end else begin
            sd_sync[0] <= sd_i;
            for (int i = 1; i < SYNC_DEPTH; i++) sd_sync[i] <= sd_sync[i-1];
        end
    end

    // Edge qualification, field assembly and counter terminal values.
    always_comb begin
        sd_s     = sd_sync[SYNC_DEPTH-1];
        rise_act = sck_rise & ~cs_s;
        fall_act = sck_fall & ~cs_s;
        cmd_nx   = {cmd_r[3:0], sd_s};
        adr_nx   = {adr_r[ADRW-5:0], sd_s};
        adr_inc  = adr_r + ADRW'(1);
        last_cmd = (cnt_r == CNTW'(1));
        last_adr = (cnt_r == CNTW'(ANIB - 1));
        last_dmy = (cnt_r == CNTW'(DUMMY - 1));
        cnt_en   = (state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_DUMMY);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) state_r <= ST_IDLE;
        else         state_r <= state_nx;
    end

    // FSM next-state logic; an unknown command is rejected as soon as it is complete.
    always_comb begin
        state_nx = state_r;
        if (cs_s) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: if (cs_fall) state_nx = ST_CMD;
                ST_CMD: begin
                    if (rise_act && last_cmd) begin
                        if (cmd_nx == CMD_READ || cmd_nx == CMD_WRITE) state_nx = ST_ADDR;
                        else                                           state_nx = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (rise_act && last_adr) begin
                        if (cmd_r == CMD_READ) state_nx = (DUMMY == 0) ? ST_RDATA : ST_DUMMY;
                        else                   state_nx = ST_WDATA;
                    end
                end
                ST_DUMMY: if (rise_act && last_dmy) state_nx = ST_RDATA;
                default: state_nx = state_r;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy_o  = (state_r != ST_IDLE);
        state_o = state_r;
    end

    // Datapath: field capture, backing-store requests, read prefetch and lane drive.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r      <= '0;
            cmd_r      <= 8'h00;
            adr_r      <= '0;
            half_r     <= 1'b0;
            whi_r      <= 4'h0;
            pref_r     <= 8'h00;
            shift_r    <= 8'h00;
            rd_pend_r  <= 1'b0;
            sd_o       <= 4'h0;
            sd_oen_o   <= 4'hF;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_adr_o  <= '0;
            mem_wdat_o <= 8'h00;
        end else begin
            mem_req_o <= 1'b0;
            // Read data is valid one clk after the request strobe; an abort drops it.
            rd_pend_r <= mem_req_o & ~mem_we_o & ~cs_s;
            if (rd_pend_r && !cs_s) pref_r <= mem_rdat_i;

            if (cs_s) begin
                sd_oen_o <= 4'hF;
                half_r   <= 1'b0;
                cnt_r    <= '0;
            end else begin
                if (state_nx != state_r)     cnt_r <= '0;
                else if (rise_act && cnt_en) cnt_r <= cnt_r + CNTW'(1);

                case (state_r)
                    ST_CMD: begin
                        if (rise_act) cmd_r <= cmd_nx;
                    end
                    ST_ADDR: begin
                        if (rise_act) begin
                            adr_r <= adr_nx;
                            // First read goes out at the last address rise to hide latency.
                            if (last_adr && cmd_r == CMD_READ) begin
                                mem_req_o <= 1'b1;
                                mem_we_o  <= 1'b0;
                                mem_adr_o <= adr_nx;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_act) begin
                            if (!half_r) begin
                                whi_r  <= sd_s;
                                half_r <= 1'b1;
                            end else begin
                                mem_req_o  <= 1'b1;
                                mem_we_o   <= 1'b1;
                                mem_adr_o  <= adr_r;
                                mem_wdat_o <= {whi_r, sd_s};
                                adr_r      <= adr_inc;
                                half_r     <= 1'b0;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fall_act) begin
                            sd_oen_o <= 4'h0;
                            if (!half_r) begin
                                sd_o    <= pref_r[7:4];
                                shift_r <= pref_r;
                                half_r  <= 1'b1;
                            end else begin
                                // Low nibble goes out; fetch the next byte behind it.
                                sd_o      <= shift_r[3:0];
                                half_r    <= 1'b0;
                                adr_r     <= adr_inc;
                                mem_req_o <= 1'b1;
                                mem_we_o  <= 1'b0;
                                mem_adr_o <= adr_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_mem_resp.sv
// Self-checking bench for qspi_mem_resp: drives QPI frames as an initiator,
// models the backing store, and scoreboards memory requests and read nibbles.
module tb_qspi_mem_resp;
    import qspi_pkg::*;

    localparam int ADRW    = 24;
    localparam int DUMMY_T = 4;
    localparam int H       = 6;

    logic            clk_i = 1'b0;
    logic            rst_in;
    logic            cs_in;
    logic            sck_i;
    logic [3:0]      sd_i;
    logic [3:0]      sd_o;
    logic [3:0]      sd_oen_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [ADRW-1:0] mem_adr_o;
    logic [7:0]      mem_wdat_o;
    logic [7:0]      mem_rdat_i = 8'h00;
    logic            busy_o;
    state_e          state_o;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [3:0]  rd_q[$];
    logic [7:0]  bram    [256];
    logic [7:0]  ref_mem [256];
    logic [32:0] mon_e;

    qspi_mem_resp #(.ADRW(ADRW), .DUMMY(DUMMY_T)) dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .cs_in      (cs_in),
        .sck_i      (sck_i),
        .sd_i       (sd_i),
        .sd_o       (sd_o),
        .sd_oen_o   (sd_oen_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_adr_o  (mem_adr_o),
        .mem_wdat_o (mem_wdat_o),
        .mem_rdat_i (mem_rdat_i),
        .busy_o     (busy_o),
        .state_o    (state_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing store: one-cycle synchronous read, write on strobe.
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) bram[mem_adr_o[7:0]] <= mem_wdat_o;
            else          mem_rdat_i <= bram[mem_adr_o[7:0]];
        end
    end

    // Request monitor: every strobe must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (rst_in === 1'b1 && mem_req_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("req_unexpected", 64'(mem_adr_o), 64'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("req", 64'({mem_we_o, mem_adr_o, (mem_we_o ? mem_wdat_o : 8'h00)}), 64'(mon_e));
            end
        end
    end

    // One SCK period: low phase with sd driven, sample, then high phase, then fall.
    task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        sd_i = d;
        repeat (H) @(negedge clk_i);
        q  = sd_o;
        oe = sd_oen_o;
        sck_i = 1'b1;
        repeat (H) @(negedge clk_i);
        sck_i = 1'b0;
    endtask

    task automatic cs_low();
        cs_in = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk_i);
        cs_in = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] adr);
        logic [3:0] q, oe;
        nib(cmd[7:4], q, oe);
        nib(cmd[3:0], q, oe);
        for (int i = 5; i >= 0; i--) nib(adr[i*4 +: 4], q, oe);
    endtask

    task automatic do_write(input logic [23:0] adr, input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0]  q, oe;
        logic [23:0] a1;
        a1 = adr + 24'd1;
        exp_q.push_back({1'b1, adr, b0});
        exp_q.push_back({1'b1, a1, b1});
        ref_mem[adr[7:0]] = b0;
        ref_mem[a1[7:0]]  = b1;
        cs_low();
        send_hdr(CMD_WRITE, adr);
        nib(b0[7:4], q, oe);
        nib(b0[3:0], q, oe);
        nib(b1[7:4], q, oe);
        nib(b1[3:0], q, oe);
        cs_high();
        check_eq("wr_queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_read(input logic [23:0] adr);
        logic [3:0]  q, oe, e;
        logic [23:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 3; i++) begin
            a = adr + 24'(i);
            exp_q.push_back({1'b0, a, 8'h00});
        end
        for (int i = 0; i < 2; i++) begin
            a = adr + 24'(i);
            b = ref_mem[a[7:0]];
            rd_q.push_back(b[7:4]);
            rd_q.push_back(b[3:0]);
        end
        cs_low();
        send_hdr(CMD_READ, adr);
        for (int i = 0; i < DUMMY_T; i++) begin
            nib(4'h0, q, oe);
            check_eq("oen_dummy", 64'(oe), 64'hF);
        end
        for (int i = 0; i < 4; i++) begin
            nib(4'h0, q, oe);
            e = rd_q.pop_front();
            check_eq("oen_data", 64'(oe), 64'h0);
            check_eq("rd_nibble", 64'(q), 64'(e));
        end
        cs_high();
        check_eq("oen_after_cs", 64'(sd_oen_o), 64'hF);
        check_eq("rd_queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Watchdog: a stuck run still reports and ends.
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Main sequence.
    initial begin
        logic [3:0] q, oe, e;
        rst_in = 1'b0;
        cs_in  = 1'b1;
        sck_i  = 1'b0;
        sd_i   = 4'h0;
        repeat (3) @(negedge clk_i);

        check_eq("rst_sd_o",     64'(sd_o),       64'h0);
        check_eq("rst_oen",      64'(sd_oen_o),   64'hF);
        check_eq("rst_req",      64'(mem_req_o),  64'h0);
        check_eq("rst_we",       64'(mem_we_o),   64'h0);
        check_eq("rst_adr",      64'(mem_adr_o),  64'h0);
        check_eq("rst_wdat",     64'(mem_wdat_o), 64'h0);
        check_eq("rst_busy",     64'(busy_o),     64'h0);
        check_eq("rst_state",    64'(state_o),    64'(ST_IDLE));

        rst_in = 1'b1;
        repeat (4) @(negedge clk_i);

        // Basic write then read back.
        do_write(24'h000010, 8'hA5, 8'h3C);
        do_read(24'h000010);

        // Address wrap on write and on read.
        do_write(24'hFFFFFF, 8'h5A, 8'hC3);
        do_read(24'hFFFFFF);

        // Unknown command: no access, lanes stay released.
        cs_low();
        send_hdr(8'h9F, 24'h000010);
        for (int i = 0; i < 4; i++) begin
            nib(4'h0, q, oe);
            check_eq("oen_ignore", 64'(oe), 64'hF);
        end
        cs_high();
        do_read(24'h000010);

        // Write aborted after one data nibble: no strobe, busy drops 3 clk after CS.
        cs_low();
        send_hdr(CMD_WRITE, 24'h000020);
        nib(4'h7, q, oe);
        repeat (H) @(negedge clk_i);
        cs_in = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq("busy_before_sync", 64'(busy_o), 64'h1);
        @(negedge clk_i);
        check_eq("busy_after_cs", 64'(busy_o), 64'h0);
        repeat (8) @(negedge clk_i);

        // Reset pulse during read data.
        exp_q.push_back({1'b0, 24'h000010, 8'h00});
        cs_low();
        send_hdr(CMD_READ, 24'h000010);
        for (int i = 0; i < DUMMY_T; i++) nib(4'h0, q, oe);
        repeat (H) @(negedge clk_i);
        e = ref_mem[8'h10][7:4];
        check_eq("rst_mid_nibble", 64'(sd_o), 64'(e));
        sck_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_in = 1'b0;
        #1;
        check_eq("rst_mid_oen",  64'(sd_oen_o),  64'hF);
        check_eq("rst_mid_busy", 64'(busy_o),    64'h0);
        check_eq("rst_mid_req",  64'(mem_req_o), 64'h0);
        check_eq("rst_mid_sd_o", 64'(sd_o),      64'h0);
        sck_i = 1'b0;
        cs_in = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_in = 1'b1;
        repeat (4) @(negedge clk_i);
        do_read(24'h000010);

        check_eq("final_req_queue", 64'(exp_q.size()), 64'd0);
        check_eq("final_rd_queue",  64'(rd_q.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_mem_resp.md
# qspi_mem_resp

QPI-mode QSPI memory responder: the target-side counterpart of the SoC's external QSPI ROM/RAM link (`wb_qspi_mem`). It decodes quad-wide command/address/data frames from an initiator and serves them from a byte-wide, synchronous backing store, such as a BRAM. The block lets an FPGA act as the external RAM/ROM for bring-up and lets benches run self-checking loopback tests. All pins are oversampled in the single `clk_i` domain.

## Interface
Parameters:
- `ADRW`, 24, frame address width in bits; must be a multiple of 4.
- `DUMMY`, 4, dummy nibble-cycles between the address and the read data; range 0..15.

Ports:
- `clk_i`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `cs_in`  in  1  chip select from the initiator, active-low.
- `sck_i`  in  1  serial clock, CPOL=0.
- `sd_i`  in  4  quad data from the initiator.
- `sd_o`  out  4  quad data to the initiator.
- `sd_oen_o`  out  4  output enable per lane; 1 = high-Z. Tri-state buffers are instantiated in the wrapper.
- `mem_req_o`  out  1  one-cycle backing-store strobe.
- `mem_we_o`  out  1  write qualifier for `mem_req_o`.
- `mem_adr_o`  out  ADRW  byte address.
- `mem_wdat_o`  out  8  write byte.
- `mem_rdat_i`  in  8  read byte; valid exactly 1 clk after a read `mem_req_o`.
- `busy_o`  out  1  high while a frame is in progress (state != IDLE).

## Operation
Input conditioning:
- `cs_in`, `sck_i` and `sd_i` each pass through a 2-FF synchronizer.
- SCK rise and fall are detected on the synchronized SCK.
- `sd` is sampled on a detected rise.
- `sd_o` is updated on a detected fall.

Frame format (all fields MSB-nibble first):
- 2 command nibbles.
- ADRW/4 address nibbles.
- Data: each byte is sent high nibble first.

Commands:
- 0x38 = write.
- 0xEB = read.
- Any other command -> IGNORE: no memory access, lanes stay high-Z until CS deasserts.

FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD on synchronized CS falling.
- CMD -> ADDR after the 2nd command nibble.
- ADDR, on the last address nibble:
  - read: issue `mem_req_o` (we=0) at the current address in the same clk; go to DUMMY, or to RDATA when DUMMY=0.
  - write: go to WDATA.
- DUMMY -> RDATA after DUMMY rising edges.
- Any state -> IDLE when synchronized CS is high. This aborts the frame: a partial write byte is discarded, and an outstanding read beat is dropped.

Read path:
- The returned byte is latched into a prefetch register.
- At each byte boundary the prefetch register moves into the output shift register; the address increments and the next read is issued.
- Falling edges in RDATA shift out the high nibble, then the low nibble.
- `sd_oen_o` = 4'b0000 from the first fall in RDATA until CS is high; otherwise 4'b1111.

Write path:
- Two rising edges assemble one byte.
- On the second rise: one-cycle `mem_req_o` with we=1, then the address increments.

Address arithmetic: increments modulo 2^ADRW, so 0xFFFFFF wraps to 0x000000.

## Timing
- Constraint: SCK high and low phases each ≥ 4 `clk_i` cycles.
- Reset values:
  - `sd_o` = 0, `sd_oen_o` = 4'hF.
  - `mem_req_o` = 0, `mem_we_o` = 0, `mem_adr_o` = 0, `mem_wdat_o` = 0.
  - `busy_o` = 0; state = IDLE.
- Pin-to-action latency: 3 clk from a pin edge to the internal action (2 sync + 1 detect).
  - Hence `sd_o` is stable ≥ 1 clk before the initiator's next rise.
- First read data: driven on the first fall after the last address/dummy rise.
  - The backing-store read completes ≥ 2 clk earlier, because its request is issued at the rise.
- Prefetch of byte n+1: requested at the fall that drives the low nibble of byte n.
- Simultaneous CS rise and SCK edge in the same clk: CS wins; the edge is ignored.
- `rst_in` asserted mid-frame: all outputs take their reset values immediately (asynchronous).

## Structure
- Package `qspi_pkg`:
  - `state_e` enum.
  - Constants `CMD_READ = 8'hEB`, `CMD_WRITE = 8'h38`.
  - The synchronizer depth.
- Sub-module `sync_edge`: 2-FF synchronizer plus rise/fall detector, instantiated once each for SCK and CS.
- The data lanes use plain 2-FF synchronizers.

## Test plan
- Write frame 0x38, addr 0x000010, data A5 3C -> `mem_req_o`/we pulses at 0x10 = 0xA5 and 0x11 = 0x3C; no further requests.
- Read frame 0xEB, addr 0x000010, DUMMY=4, backing store returning 0xA5 0x3C -> nibbles A,5,3,C on `sd_o`; `sd_oen_o` = 0 only during data.
- Read at addr 0xFFFFFF, 2 bytes -> requests at 0xFFFFFF, then 0x000000.
- Command 0x9F -> no `mem_req_o`; `sd_oen_o` stays 4'hF; next valid frame works.
- CS raised after 1 data nibble of a write -> no write strobe; `busy_o` falls 3 clk after CS rise.
- `rst_in` pulsed during RDATA -> `sd_oen_o` = 4'hF immediately; a following read frame returns correct data.
